// File: rtl/tt_sweep_if.sv
// Start/status and function-stimulus bundle for tt_sweep_ctrl.
// With TT_SWEEP_CAPTURE_EN defined, the captured truth table tt_a is carried as well.
interface tt_sweep_if;
  logic       start;
  logic       x;
  logic       y;
  logic       z;
  logic       a;
  logic       sa;
  logic       busy;
  logic       done;
  logic       pass;
  logic [3:0] err_count;
  logic [2:0] first_err;
  logic       first_err_valid;
`ifdef TT_SWEEP_CAPTURE_EN
  logic [7:0] tt_a;
`endif

  // Environment side: issues start, returns the two function outputs.
  modport master (
    output start, a, sa,
    input  x, y, z, busy, done, pass, err_count, first_err, first_err_valid
`ifdef TT_SWEEP_CAPTURE_EN
    , tt_a
`endif
  );

  // Sequencer side.
  modport slave (
    input  start, a, sa,
    output x, y, z, busy, done, pass, err_count, first_err, first_err_valid
`ifdef TT_SWEEP_CAPTURE_EN
    , tt_a
`endif
  );
endinterface

// File: rtl/tt_sweep_ctrl.sv
// Sweeps x,y,z through 0..7, compares the full (a) and simplified (sa) function outputs
// and reports mismatch count and first failing vector. Optional TT_SWEEP_CAPTURE_EN adds tt_a.
module tt_sweep_ctrl #(
  parameter int unsigned SETTLE = 1
) (
  input logic       clk,
  input logic       reset,
  tt_sweep_if.slave bus
);

  typedef enum logic [1:0] {IDLE, WAIT, SAMPLE, DONE} state_t;

  localparam logic [3:0] SETTLE_CNT = 4'(SETTLE);
  // With no settle time a vector goes straight to sampling.
  localparam state_t VEC_STATE = (SETTLE == 0) ? SAMPLE : WAIT;

  state_t     state;
  logic [2:0] idx;
  logic [3:0] cnt;
  logic [2:0] xyz_q;
  logic       busy_q;
  logic       done_q;
  logic       pass_q;
  logic [3:0] err_q;
  logic [2:0] first_q;
  logic       first_valid_q;
  logic       mismatch;
`ifdef TT_SWEEP_CAPTURE_EN
  logic [7:0] tt_a_q;
`endif

  assign mismatch = bus.a ^ bus.sa;

  // NOTE: every register, including state, is cleared asynchronously so a mid-sweep
  // reset leaves no partial result behind.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      idx           <= '0;
      cnt           <= '0;
      xyz_q         <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      pass_q        <= 1'b0;
      err_q         <= '0;
      first_q       <= '0;
      first_valid_q <= 1'b0;
`ifdef TT_SWEEP_CAPTURE_EN
      tt_a_q        <= '0;
`endif
    end else begin
      // NOTE: non-blocking assignments throughout; SAMPLE reads err_q/idx before update.
      case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            state         <= VEC_STATE;
            idx           <= '0;
            cnt           <= SETTLE_CNT;
            xyz_q         <= '0;
            busy_q        <= 1'b1;
            done_q        <= 1'b0;
            pass_q        <= 1'b0;
            err_q         <= '0;
            first_q       <= '0;
            first_valid_q <= 1'b0;
`ifdef TT_SWEEP_CAPTURE_EN
            tt_a_q        <= '0;
`endif
          end
        end

        WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) state <= SAMPLE;
        end

        SAMPLE: begin
          if (mismatch) begin
            err_q <= err_q + 4'd1;
            if (!first_valid_q) begin
              first_q       <= idx;
              first_valid_q <= 1'b1;
            end
          end
`ifdef TT_SWEEP_CAPTURE_EN
          tt_a_q[idx] <= bus.a;
`endif
          if (idx == 3'd7) begin
            state  <= DONE;
            xyz_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b1;
            // Final verdict has to include the vector sampled on this very edge.
            pass_q <= (err_q == 4'd0) && !mismatch;
          end else begin
            state <= VEC_STATE;
            idx   <= idx + 3'd1;
            xyz_q <= idx + 3'd1;
            cnt   <= SETTLE_CNT;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign bus.x               = xyz_q[2];
  assign bus.y               = xyz_q[1];
  assign bus.z               = xyz_q[0];
  assign bus.busy            = busy_q;
  assign bus.done            = done_q;
  assign bus.pass            = pass_q;
  assign bus.err_count       = err_q;
  assign bus.first_err       = first_q;
  assign bus.first_err_valid = first_valid_q;
`ifdef TT_SWEEP_CAPTURE_EN
  assign bus.tt_a            = tt_a_q;
`endif

endmodule

// File: doc/tt_sweep_ctrl.md
Name: tt_sweep_ctrl

Overview:
- Sequencer that drives a pair of 3-input combinational functions (full sum-of-products and its Karnaugh-simplified form) through all 8 input vectors.
- Samples both outputs per vector and reports equivalence, mismatch count and first failing vector.
- Sits between a start/status interface and the two function instances; replaces the hand-written stimulus sequence with a hardware self-check.

Parameters:
SETTLE, 1, wait cycles after applying a vector before sampling a/sa (legal 0..15; 0 = sample in the cycle after apply)

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-high reset
start  in  1  launch request; honoured only in IDLE or DONE
x  out  1  vector MSB to both functions (idx[2])
y  out  1  vector middle bit (idx[1])
z  out  1  vector LSB (idx[0])
a  in  1  output of full-expression instance
sa  in  1  output of simplified-expression instance
busy  out  1  high while sweeping
done  out  1  high in DONE, results valid
pass  out  1  done && err_count==0
err_count  out  4  number of mismatching vectors (0..8)
first_err  out  3  index {x,y,z} of first mismatch
first_err_valid  out  1  at least one mismatch recorded

Behaviour:
- Reset (async, any state) -> state IDLE:
  - idx=0, wait counter=0, x=y=z=0, busy=0, done=0, pass=0, err_count=0, first_err=0, first_err_valid=0.
- States: IDLE, WAIT, SAMPLE, DONE.
- IDLE: outputs x/y/z=0. start=1 at edge E0 -> idx=0, err_count/first_err/first_err_valid cleared, cnt=SETTLE.
  - Next state WAIT if SETTLE>0, else SAMPLE.
- WAIT: {x,y,z}=idx. cnt decrements each edge; at cnt==1 -> SAMPLE.
- SAMPLE: {x,y,z}=idx. At the ending edge, compare a vs sa:
  - On mismatch: err_count+1.
  - On mismatch with first_err_valid=0: first_err=idx, first_err_valid=1.
  - If idx==7 -> DONE. Else idx+1, cnt=SETTLE, -> WAIT (or SAMPLE if SETTLE==0).
- Vector order: ascending 0..7, x is MSB.
- Latency: each vector takes SETTLE+1 cycles. busy is high from E0 through E0+8*(SETTLE+1); done rises at edge E0+8*(SETTLE+1).
- DONE: busy=0, done=1, x=y=z=0. Results held indefinitely.
  - start in DONE behaves as in IDLE: new sweep, results cleared at that edge, done drops.
- start while busy: ignored, with no effect on idx or counters.
- err_count never exceeds 8; no wrap logic needed beyond 4 bits. idx does not wrap past 7.
- a/sa are sampled only in SAMPLE; values in other states are don't-care.
- Reset asserted mid-sweep: immediate return to IDLE with all outputs at reset values; no partial results are retained.

Optional Feature:
TT_SWEEP_CAPTURE_EN
- Defined: adds output tt_a[7:0] (reset 0, cleared at sweep launch). In SAMPLE, bit idx is set to the sampled value of a, so after DONE tt_a holds the full truth table of the full-expression instance.
- Undefined: port and register are absent; all other behaviour is identical.

Test Plan:
- Functions a = x&y&~z | x&~y&~z | x&~y&z and sa = x&(~z|~y), SETTLE=1, start pulse at E0 -> done at E16, pass=1, err_count=0, first_err_valid=0, tt_a=8'h70.
- sa replaced by x&~z, SETTLE=1 -> mismatch only at idx 5: err_count=1, first_err=3'd5, first_err_valid=1, pass=0.
- sa tied to ~a -> err_count=8, first_err=0, first_err_valid=1, pass=0.
- SETTLE=0 with correct pair -> done at E8, busy high exactly 8 cycles, x/y/z step 0..7 one per cycle.
- start held high throughout sweep, then reset asserted asynchronously at E5 -> busy/done/err_count/x/y/z go 0 without waiting for an edge.
  - After reset release, a start pulse gives a full clean sweep from idx 0.
- After a DONE with err_count=1, pulse start -> results clear at that edge and the second sweep with the correct pair ends pass=1.
